// File: rtl/max_pooling_layer.sv
// 2x2 stride-2 signed max pooling over a raster pixel stream.
// A single line buffer holds the pooled pairs from the top row of each window.
module max_pooling_layer #(
  parameter int Q_WIDTH    = -1,
  parameter int Q_CHANNELS = -1,
  parameter int INPUT_SIZE = -1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clk_en,
  input  logic                           input_valid,
  input  logic [Q_WIDTH*Q_CHANNELS-1:0]  input_data,
  output logic [Q_WIDTH*Q_CHANNELS-1:0]  output_data,
  output logic                           valid
);

  localparam int QW       = (Q_WIDTH > 0) ? Q_WIDTH : 1;
  localparam int QC       = (Q_CHANNELS > 0) ? Q_CHANNELS : 1;
  localparam int DW       = Q_WIDTH * Q_CHANNELS;
  localparam int SIZE     = (INPUT_SIZE >= 2) ? INPUT_SIZE : 2;
  localparam int HALF     = SIZE / 2;
  localparam int CNT_W    = $clog2(SIZE);
  localparam int IDX_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam bit SIZE_ODD = (SIZE % 2) == 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [DW-1:0]    hold;
  logic [DW-1:0]    linebuf [HALF];
  logic [IDX_W-1:0] lb_idx;
  logic [DW-1:0]    lb_rd;
  logic [DW-1:0]    pair_max;
  logic [DW-1:0]    quad_max;
  logic             accept;
  logic             take;
  logic             lb_we;
  logic             out_we;

  assign accept = clk_en & input_valid;
  // With an odd frame size the last column and last row never complete a window.
  assign take   = accept
                & ~(SIZE_ODD && (col == LAST))
                & ~(SIZE_ODD && (row == LAST));
  assign lb_we  = take & col[0] & ~row[0];
  assign out_we = take & col[0] & row[0];
  assign lb_idx = IDX_W'(col >> 1);
  assign lb_rd  = linebuf[lb_idx];

  for (genvar c = 0; c < QC; c++) begin : g_ch
    logic signed [QW-1:0] h_s;
    logic signed [QW-1:0] p_s;
    logic signed [QW-1:0] l_s;
    logic signed [QW-1:0] hp_max;
    assign h_s    = hold[c*QW +: QW];
    assign p_s    = input_data[c*QW +: QW];
    assign l_s    = lb_rd[c*QW +: QW];
    assign hp_max = (p_s > h_s) ? p_s : h_s;
    assign pair_max[c*QW +: QW] = hp_max;
    assign quad_max[c*QW +: QW] = (l_s > hp_max) ? l_s : hp_max;
  end

  // Line buffer is left unreset: each entry is written on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      output_data <= '0;
      col         <= '0;
      row         <= '0;
      hold        <= '0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (take && !col[0]) begin
          hold <= input_data;
        end
        if (out_we) begin
          output_data <= quad_max;
          valid       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pooling_layer.sv
// Directed bench for max_pooling_layer: a 4x4 two-channel instance and a 5x5 single-channel instance.
module tb_max_pooling_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en4, iv4, vout4;
  logic [15:0] din4, dout4;
  logic        en5, iv5, vout5;
  logic [7:0]  din5, dout5;

  int          n_checks = 0;
  int          n_errors = 0;
  int          pos4 = 0;
  int          pos5 = 0;
  logic [15:0] last4 = '0;
  logic [7:0]  last5 = '0;
  logic [15:0] exp_q4 [$];
  logic [7:0]  exp_q5 [$];
  logic [15:0] sgn_frame [16];

  always #5 clk = ~clk;

  max_pooling_layer #(.Q_WIDTH(8), .Q_CHANNELS(2), .INPUT_SIZE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clk_en(en4), .input_valid(iv4),
    .input_data(din4), .output_data(dout4), .valid(vout4)
  );

  max_pooling_layer #(.Q_WIDTH(8), .Q_CHANNELS(1), .INPUT_SIZE(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clk_en(en5), .input_valid(iv5),
    .input_data(din5), .output_data(dout5), .valid(vout5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ch0 carries v, ch1 carries -v, so ch1 pools to -min of the window.
  function automatic logic [15:0] px(input int v);
    return {8'(-v), 8'(v)};
  endfunction

  function automatic logic [15:0] win(input int mx, input int mn);
    return {8'(-mn), 8'(mx)};
  endfunction

  task automatic drive4(input logic [15:0] d, input bit en, input bit iv);
    bit exp_v;
    en4 = en; iv4 = iv; din4 = d;
    @(posedge clk); #1;
    exp_v = 1'b0;
    if (en && iv) begin
      exp_v = (pos4 == 5 || pos4 == 7 || pos4 == 13 || pos4 == 15);
      pos4  = (pos4 + 1) % 16;
    end
    if (exp_v) last4 = (exp_q4.size() > 0) ? exp_q4.pop_front() : 16'hxxxx;
    check("valid4", {31'd0, vout4}, {31'd0, exp_v});
    check("data4", {16'd0, dout4}, {16'd0, last4});
    en4 = 1'b0; iv4 = 1'b0;
  endtask

  task automatic drive5(input logic [7:0] d);
    bit exp_v;
    en5 = 1'b1; iv5 = 1'b1; din5 = d;
    @(posedge clk); #1;
    exp_v = (pos5 == 6 || pos5 == 8 || pos5 == 16 || pos5 == 18);
    pos5  = (pos5 + 1) % 25;
    if (exp_v) last5 = (exp_q5.size() > 0) ? exp_q5.pop_front() : 8'hxx;
    check("valid5", {31'd0, vout5}, {31'd0, exp_v});
    check("data5", {24'd0, dout5}, {24'd0, last5});
    en5 = 1'b0; iv5 = 1'b0;
  endtask

  task automatic stall4();
    case ($urandom_range(0, 2))
      0:       drive4(16'hA5A5, 1'b0, 1'b1);
      1:       drive4(16'h5A5A, 1'b1, 1'b0);
      default: drive4(16'h7E7E, 1'b0, 1'b0);
    endcase
  endtask

  task automatic push_up4();
    exp_q4.push_back(win(6, 1));
    exp_q4.push_back(win(8, 3));
    exp_q4.push_back(win(14, 9));
    exp_q4.push_back(win(16, 11));
  endtask

  initial begin
    rst_n = 1'b0;
    en4 = 1'b0; iv4 = 1'b0; din4 = '0;
    en5 = 1'b0; iv5 = 1'b0; din5 = '0;
    #12;
    check("rst_valid4", {31'd0, vout4}, 32'd0);
    check("rst_data4", {16'd0, dout4}, 32'd0);
    check("rst_valid5", {31'd0, vout5}, 32'd0);
    check("rst_data5", {24'd0, dout5}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 5x5: trailing column and row ignored, two frames back to back
    for (int f = 0; f < 2; f++) begin
      exp_q5.push_back(8'd7);
      exp_q5.push_back(8'd9);
      exp_q5.push_back(8'd17);
      exp_q5.push_back(8'd19);
      for (int v = 1; v <= 25; v++) drive5(8'(v));
    end
    check("q5_drained", exp_q5.size(), 32'd0);

    // 4x4 basic frame then reversed frame with no gap
    push_up4();
    exp_q4.push_back(win(16, 11));
    exp_q4.push_back(win(14, 9));
    exp_q4.push_back(win(8, 3));
    exp_q4.push_back(win(6, 1));
    for (int v = 1; v <= 16; v++) drive4(px(v), 1'b1, 1'b1);
    for (int v = 16; v >= 1; v--) drive4(px(v), 1'b1, 1'b1);
    check("q4_drained_b2b", exp_q4.size(), 32'd0);

    // signed, per-channel independent window; remaining windows are all zero
    for (int i = 0; i < 16; i++) sgn_frame[i] = 16'h0000;
    sgn_frame[0] = {8'd7,   8'hFB};
    sgn_frame[1] = {8'h80,  8'hFD};
    sgn_frame[4] = {8'h7F,  8'hF8};
    sgn_frame[5] = {8'h00,  8'hFF};
    exp_q4.push_back(16'h7FFF);
    exp_q4.push_back(16'h0000);
    exp_q4.push_back(16'h0000);
    exp_q4.push_back(16'h0000);
    for (int i = 0; i < 16; i++) drive4(sgn_frame[i], 1'b1, 1'b1);
    check("q4_drained_signed", exp_q4.size(), 32'd0);

    // stalls, including one right after an output-producing pixel
    push_up4();
    for (int v = 1; v <= 16; v++) begin
      if (v == 7) drive4(16'h1111, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) stall4();
      drive4(px(v), 1'b1, 1'b1);
    end
    check("q4_drained_stall", exp_q4.size(), 32'd0);

    // mid-frame reset after pixel 7
    push_up4();
    for (int v = 1; v <= 7; v++) drive4(px(v), 1'b1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid4", {31'd0, vout4}, 32'd0);
    check("midrst_data4", {16'd0, dout4}, 32'd0);
    check("midrst_data5", {24'd0, dout5}, 32'd0);
    exp_q4.delete();
    pos4 = 0;
    last4 = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_up4();
    for (int v = 1; v <= 16; v++) drive4(px(v), 1'b1, 1'b1);
    check("q4_drained_fresh", exp_q4.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/max_pooling_layer.md
MAX_POOLING_LAYER -- requirements
Module: max_pooling_layer

Interface
REQ-001 SHALL have parameter Q_WIDTH, default -1: bits per channel sample, two's-complement signed.
REQ-002 SHALL have parameter Q_CHANNELS, default -1: channels per pixel.
REQ-003 SHALL have parameter INPUT_SIZE, default -1: input frame width and height in pixels; legal values are >= 2.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port clk_en, input, 1: stage enable, shared with the upstream convolutional stage.
REQ-007 SHALL have port input_valid, input, 1: input_data carries a valid pixel (driven by the upstream valid).
REQ-008 SHALL have port input_data, input, Q_WIDTH*Q_CHANNELS: one pixel, with channel i in bits [Q_WIDTH*(i+1)-1 : Q_WIDTH*i].
REQ-009 SHALL have port output_data, output, Q_WIDTH*Q_CHANNELS: one pooled pixel, same channel packing as input_data.
REQ-010 SHALL have port valid, output, 1: output_data holds a new pooled pixel.

Function
REQ-011 SHALL accept a pixel only on a rising edge where clk_en=1 and input_valid=1; otherwise all internal state is held.
REQ-012 SHALL treat accepted pixels as a raster stream: row-major, column counter col 0..INPUT_SIZE-1, row counter row 0..INPUT_SIZE-1.
REQ-013 SHALL perform 2x2 max pooling with stride 2, producing (INPUT_SIZE/2)x(INPUT_SIZE/2) outputs per frame, using integer division.
REQ-014 SHALL compare per channel, independently, using a signed comparison.
REQ-015 SHALL load an accepted pixel at even col into a horizontal hold register.
REQ-016 SHALL, for an accepted pixel at odd col on an even row, write max(hold, pixel) to line-buffer entry col/2.
REQ-017 SHALL provide a line buffer of INPUT_SIZE/2 entries, each Q_WIDTH*Q_CHANNELS bits wide.
REQ-018 SHALL, for an accepted pixel at odd col on an odd row, register max(hold, pixel, linebuf[col/2]) into output_data and set valid=1 on the same edge; latency is 1 clock from the accepting edge.
REQ-019 SHALL drive valid=1 for exactly one clock per pooled pixel, regardless of clk_en in the following cycle.
REQ-020 SHALL hold output_data at its last value while valid=0.
REQ-021 SHALL ignore pixels in the trailing column/row when INPUT_SIZE is odd: counters advance, but no hold, line-buffer or output update occurs for those pixels.
REQ-022 SHALL wrap col from INPUT_SIZE-1 to 0 and increment row; after row INPUT_SIZE-1, col INPUT_SIZE-1, both counters SHALL return to 0 and the next frame follows with no gap cycle.
REQ-023 SHALL size the counters to hold INPUT_SIZE-1 (`LOG2 convention of the codebase).
REQ-024 SHALL use equal-value ties transparently; the output is the common value.

Reset
REQ-025 SHALL, on rst_n=0, clear immediately (asynchronously) valid=0, output_data=0, col=0, row=0, hold=0.
REQ-026 SHALL leave line-buffer contents unreset; every entry is written before it is read.
REQ-027 SHALL, on reset asserted mid-frame, discard the partial frame; the first pixel accepted after release is col 0, row 0.

Verification
REQ-028 Scenario, basic pooling: INPUT_SIZE=4, Q_CHANNELS=1, Q_WIDTH=8, clk_en=1, input_valid=1, pixels 1..16 in raster order -> valid pulses carrying 6, 8, 14, 16, each one clock after pixels 6, 8, 14, 16.
REQ-029 Scenario, signed and multi-channel: Q_CHANNELS=2, ch0 window {-5,-3,-8,-1}, ch1 window {7,-128,127,0} -> output ch0=-1 (0xFF), ch1=127 (0x7F).
REQ-030 Scenario, stalls: the REQ-028 stream with clk_en or input_valid low on random cycles -> identical output sequence; no valid pulse during stalls except the one clock following an accepting edge.
REQ-031 Scenario, odd size: INPUT_SIZE=5, pixels 1..25 -> exactly 4 outputs: 7, 9, 17, 19; column 4 and row 4 are ignored.
REQ-032 Scenario, mid-frame reset: rst_n low after pixel 7 of a 4x4 frame -> valid=0 and output_data=0 immediately; a fresh frame of 1..16 then yields 6, 8, 14, 16.
REQ-033 Scenario, back-to-back frames: two 4x4 frames with no gap (second frame 16..1) -> 6, 8, 14, 16, then 16, 14, 8, 6, with correct line-buffer reuse.
